// File: rtl/if_stage.sv
// Instruction fetch stage: issues single-outstanding word fetches to the
// instruction memory, holds the returned instruction for decode, and tracks
// redirects (discarding in-flight responses) and misaligned redirect targets.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request/response
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // control-flow redirect
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // decode handshake
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_exc
);

  // READY: nothing outstanding; WAIT: one outstanding, keep its response;
  // DROP: one outstanding, discard its response (a redirect overtook it).
  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] req_pc_q,   req_pc_d;
  logic        fault_q,    fault_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q,    if_pc_d;

  logic        fetch_fire;
  logic        consume;

  // Request only when idle, not faulted, not redirecting, and the output
  // register is free or being drained this cycle.
  always_comb begin
    imem_req   = (state_q == ST_READY) & ~fault_q & ~rst & ~redirect_valid &
                 (~if_valid_q | id_ready);
    imem_addr  = pc_q;
    fetch_fire = imem_req & imem_gnt;
    consume    = if_valid_q & id_ready;
  end

  // Drive the decode-facing outputs from their registers.
  always_comb begin
    if_valid     = if_valid_q;
    if_instr     = if_instr_q;
    if_pc        = if_pc_q;
    if_pc_plus4  = if_pc_q + 32'd4;
    misalign_exc = fault_q;
  end

  // Next-state logic; a redirect takes priority over every other update,
  // and a response load takes priority over draining the output register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    fault_d    = fault_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      fault_d    = |redirect_pc[1:0];
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      // Any outstanding request (and a response arriving now) is stale.
      if (state_q != ST_READY) begin
        state_d = ST_DROP;
      end
    end else begin
      if (consume) begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
      case (state_q)
        ST_READY: begin
          if (fetch_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
            state_d    = ST_READY;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_d = ST_READY;
          end
        end
        default: begin
          state_d = ST_READY;
        end
      endcase
    end
  end

  // State registers with synchronous reset overriding everything, including
  // a redirect in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_READY;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      fault_q    <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      fault_q    <= fault_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed stimulus pushes expected fetch addresses
// and delivered instructions into queues; a monitor pops and compares them
// whenever a request handshake or a decode handshake occurs.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_exc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic [31:0] exp_addr_q[$];
  exp_t        exp_instr_q[$];

  int unsigned checks;
  int unsigned failures;

  if_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .misalign_exc  (misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // Monitor: compare at mid-cycle, when inputs and combinational outputs are settled.
  always @(negedge clk) begin
    if (imem_req && imem_gnt) begin
      if (exp_addr_q.size() == 0) begin
        flag("unexpected_fetch", imem_addr);
      end else begin
        chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
    end
    if (if_valid && id_ready) begin
      if (exp_instr_q.size() == 0) begin
        flag("unexpected_instr", if_instr);
      end else begin
        exp_t e;
        e = exp_instr_q.pop_front();
        chk("instr", if_instr, e.instr);
        chk("instr_pc", if_pc, e.pc);
        chk("instr_pc4", if_pc_plus4, e.pc4);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant one request to the expected address; bounded wait for imem_req.
  task automatic grant_one(input logic [31:0] a);
    int unsigned n;
    n = 0;
    exp_addr_q.push_back(a);
    imem_gnt = 1'b1;
    #1;
    while (!imem_req && n < 16) begin
      step();
      #1;
      n++;
    end
    chk("grant_req_seen", {31'b0, imem_req}, 32'd1);
    step();
    imem_gnt = 1'b0;
  endtask

  // Return one response; keep=1 means decode must eventually see it.
  task automatic respond(input logic [31:0] data, input logic keep, input logic [31:0] pc);
    exp_t e;
    if (keep) begin
      e.instr = data;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      exp_instr_q.push_back(e);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, NOP_INSTR);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    rst = 1'b0;

    // First fetch: address 0, response one cycle after grant
    grant_one(32'h0000_0000);
    respond(32'h0050_0093, 1'b1, 32'h0000_0000);
    chk("t1_valid", {31'b0, if_valid}, 32'd1);
    chk("t1_instr", if_instr, 32'h0050_0093);
    chk("t1_pc", if_pc, 32'h0000_0000);
    chk("t1_pc4", if_pc_plus4, 32'h0000_0004);
    chk("t1_addr", imem_addr, 32'h0000_0004);

    // Decode stall holds the output registers and blocks requests
    grant_one(32'h0000_0004);
    id_ready = 1'b0;
    respond(32'h00A0_0113, 1'b1, 32'h0000_0004);
    for (int unsigned i = 0; i < 5; i++) begin
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_instr", if_instr, 32'h00A0_0113);
      chk("stall_pc", if_pc, 32'h0000_0004);
      step();
    end
    id_ready = 1'b1;
    grant_one(32'h0000_0008);

    // Redirect while 0x8 is outstanding; second redirect in DROP wins
    redirect(32'h0000_0140);
    chk("rd_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_req_drop", {31'b0, imem_req}, 32'd0);
    chk("rd_addr1", imem_addr, 32'h0000_0140);
    redirect(32'h0000_0100);
    chk("rd_addr2", imem_addr, 32'h0000_0100);
    respond(32'hDEAD_BEEF, 1'b0, 32'h0000_0008);
    chk("drop_valid", {31'b0, if_valid}, 32'd0);
    chk("drop_instr", if_instr, NOP_INSTR);
    grant_one(32'h0000_0100);
    respond(32'h0010_0193, 1'b1, 32'h0000_0100);
    chk("rd_resp_pc", if_pc, 32'h0000_0100);

    // Misaligned redirect faults and halts fetch; aligned redirect clears it
    imem_gnt = 1'b1;
    redirect(32'h0000_0102);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("fault_exc", {31'b0, misalign_exc}, 32'd1);
      chk("fault_req", {31'b0, imem_req}, 32'd0);
      step();
    end
    imem_gnt = 1'b0;
    redirect(32'h0000_0200);
    chk("clear_exc", {31'b0, misalign_exc}, 32'd0);
    chk("clear_addr", imem_addr, 32'h0000_0200);
    grant_one(32'h0000_0200);
    respond(32'h0030_0213, 1'b1, 32'h0000_0200);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    grant_one(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    respond(32'h0020_8233, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0000_0000);

    // Reset mid-WAIT, with a redirect in the same cycle and a late response
    grant_one(32'h0000_0000);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0303;
    #1;
    chk("rst2_req_during", {31'b0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    chk("rst2_misalign", {31'b0, misalign_exc}, 32'd0);
    chk("rst2_valid", {31'b0, if_valid}, 32'd0);
    chk("rst2_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    respond(32'hBAD0_BAD0, 1'b0, 32'h0000_0000);
    chk("late_valid", {31'b0, if_valid}, 32'd0);
    chk("late_instr", if_instr, NOP_INSTR);
    chk("late_pc", if_pc, 32'd0);
    chk("late_req", {31'b0, imem_req}, 32'd1);
    grant_one(RESET_PC);
    respond(32'h0040_0293, 1'b1, RESET_PC);

    step();
    step();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("instr_q_empty", exp_instr_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the if_instr value when no instruction is held.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address (word aligned).
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  response valid; at least 1 cycle after grant, in order.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 redirect_valid  input  1  branch/jump/trap redirect this cycle.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 id_ready  input  1  decode accepts if_instr this cycle.
REQ-013 if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-014 if_instr  output  32  instruction to decode and immediate generation.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 if_pc_plus4  output  32  if_pc + 4, mod 2^32.
REQ-017 misalign_exc  output  1  fetch halted on a misaligned redirect target.

Function
REQ-018 SHALL keep a state register with states READY (no outstanding request), WAIT (one outstanding, keep), DROP (one outstanding, discard), a pc register, a req_pc register and a fault flag.
REQ-019 SHALL allow at most one outstanding request.
REQ-020 imem_req = (state==READY) & ~fault & ~rst & ~redirect_valid & (~if_valid | id_ready); imem_addr = pc at all times.
REQ-021 On imem_req & imem_gnt: req_pc <= pc, pc <= pc+4 (mod 2^32 wrap), state READY->WAIT.
REQ-022 In WAIT on imem_rvalid: if_instr <= imem_rdata, if_pc <= req_pc, if_valid <= 1, state -> READY; the earliest following request is the same cycle as the response only if REQ-020 holds at that point (state is sampled registered, so the next request is issued the cycle after the response).
REQ-023 In DROP on imem_rvalid: the response is discarded and the outputs are unchanged; state -> READY.
REQ-024 imem_rvalid in READY SHALL be ignored.
REQ-025 On if_valid & id_ready without a new load the same edge: if_valid <= 0, if_instr <= NOP_INSTR.
REQ-026 On redirect_valid: pc <= redirect_pc; if_valid <= 0; if_instr <= NOP_INSTR; WAIT -> DROP; a response arriving the same cycle is discarded; redirect has priority over every other update.
REQ-027 A redirect while in DROP SHALL stay in DROP, with the latest redirect_pc winning.
REQ-028 A redirect with redirect_pc[1:0]!=0 SHALL set fault; an aligned redirect SHALL clear it; while fault=1, misalign_exc=1 and no requests are issued.
REQ-029 The output registers SHALL hold while if_valid=1 and id_ready=0 (stall); no request is issued then.
REQ-030 if_pc_plus4 SHALL be combinational from if_pc.

Reset
REQ-031 While rst=1 at an edge: pc <= RESET_PC, state <= READY, fault <= 0, if_valid <= 0, if_instr <= NOP_INSTR, if_pc <= 0.
REQ-032 While rst=1, imem_req SHALL be 0, and misalign_exc = 0 from the following cycle.
REQ-033 Reset mid-operation SHALL abandon any outstanding request; a late imem_rvalid after reset SHALL be ignored (state READY).
REQ-034 Reset SHALL override redirect_valid in the same cycle.

Verification
REQ-035 Reset release, gnt=1, rvalid 1 cycle later with rdata=32'h00500093, id_ready=1 -> imem_addr 0 then 4; if_valid=1, if_instr=32'h00500093, if_pc=0, if_pc_plus4=4.
REQ-036 if_valid=1 and id_ready=0 for 5 cycles -> if_instr/if_pc stable and imem_req=0; id_ready=1 -> the next request goes to pc+4.
REQ-037 Request to 0x8 granted, redirect to 0x100 before rvalid -> the 0x8 response is dropped, if_valid=0, the next imem_addr is 0x100, and the later response carries if_pc=0x100.
REQ-038 Redirect to 0x102 -> misalign_exc=1 and no imem_req; redirect to 0x200 -> misalign_exc=0 and a request to 0x200.
REQ-039 Redirect to 0xFFFF_FFFC, fetch granted -> pc wraps to 0; if_pc_plus4=0 for that instruction.
REQ-040 rst asserted while in WAIT, rvalid the next cycle -> outputs stay at their reset values, then the first request goes to RESET_PC.
